input_debouncer: RTL and testbench

//  Conditions a raw, asynchronous, bouncy input into the clean level 'a'

---
 rtl/input_debouncer.sv | 116 +++++++++++
 tb/tb_input_debouncer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Synchronises and debounces a raw asynchronous input into the clean level 'a',
// with one-cycle rise/fall strobes on each committed change.
module input_debouncer #(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter int   CNT_W           = 16,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_in,
  output logic a,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    CHK_HI    = 2'b01,
    STABLE_HI = 2'b10,
    CHK_LO    = 2'b11
  } state_t;

  localparam state_t RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             a_next, rise_next, fall_next;
  logic             sync1, sync2;

  // Two-flop synchroniser; only sync2 is allowed to influence the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RESET_STATE;
      cnt   <= '0;
      a     <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      a     <= a_next;
      rise  <= rise_next;
      fall  <= fall_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    a_next     = a;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state)
      STABLE_LO: begin
        a_next = 1'b0;
        if (sync2) begin
          state_next = CHK_HI;
          cnt_next   = '0;
        end
      end
      CHK_HI: begin
        if (!sync2) begin
          state_next = STABLE_LO;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
          a_next     = 1'b1;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        a_next = 1'b1;
        if (!sync2) begin
          state_next = CHK_LO;
          cnt_next   = '0;
        end
      end
      CHK_LO: begin
        if (sync2) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = STABLE_LO;
          cnt_next   = '0;
          a_next     = 1'b0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = STABLE_LO;
        cnt_next   = '0;
        a_next     = 1'b0;
      end
    endcase
  end

  assign busy = (state == CHK_HI) || (state == CHK_LO);

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: a D=4 and a D=1 instance share one stimulus and are
// compared each cycle against a run-length reference model.
module tb_input_debouncer;

  localparam int D0 = 4;
  localparam int D1 = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic raw_in = 1'b0;
  logic a0, rise0, fall0, busy0;
  logic a1, rise1, fall1, busy1;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: a level commits once the synchronised input has disagreed
  // with it for D+1 consecutive edges; any agreement resets the run.
  int   mD   [2] = '{D0, D1};
  logic mSync1[2], mSync2[2], mA[2], mRise[2], mFall[2];
  int   mRun [2];

  int edgeIdx, firstRise0, firstFall0, firstBusy0, firstChange1;

  input_debouncer #(.DEBOUNCE_CYCLES(D0), .CNT_W(16), .RESET_LEVEL(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_in),
    .a(a0), .rise(rise0), .fall(fall0), .busy(busy0)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(D1), .CNT_W(16), .RESET_LEVEL(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_in),
    .a(a1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mSync1[i] = 1'b0; mSync2[i] = 1'b0; mA[i] = 1'b0;
      mRise[i] = 1'b0;  mFall[i] = 1'b0;  mRun[i] = 0;
    end
  endtask

  task automatic modelEdge(input logic v);
    logic s;
    for (int i = 0; i < 2; i++) begin
      s = mSync2[i];
      mSync2[i] = mSync1[i];
      mSync1[i] = v;
      mRise[i] = 1'b0;
      mFall[i] = 1'b0;
      if (s != mA[i]) begin
        mRun[i]++;
        if (mRun[i] == mD[i] + 1) begin
          mA[i] = s;
          mRise[i] = s;
          mFall[i] = !s;
          mRun[i] = 0;
        end
      end else begin
        mRun[i] = 0;
      end
    end
  endtask

  task automatic markEdges();
    edgeIdx = 0; firstRise0 = 0; firstFall0 = 0; firstBusy0 = 0; firstChange1 = 0;
  endtask

  // One clock of stimulus; outputs are compared 1 time unit after the edge.
  task automatic applyStimulus(input logic v);
    logic a1Before;
    a1Before = a1;
    raw_in = v;
    @(posedge clk);
    modelEdge(v);
    #1;
    edgeIdx++;
    checkOutput("a0", a0, mA[0]);
    checkOutput("rise0", rise0, mRise[0]);
    checkOutput("fall0", fall0, mFall[0]);
    checkOutput("busy0", busy0, mRun[0] > 0);
    checkOutput("a1", a1, mA[1]);
    checkOutput("rise1", rise1, mRise[1]);
    checkOutput("fall1", fall1, mFall[1]);
    checkOutput("busy1", busy1, mRun[1] > 0);
    if (rise0 && firstRise0 == 0) firstRise0 = edgeIdx;
    if (fall0 && firstFall0 == 0) firstFall0 = edgeIdx;
    if (busy0 && firstBusy0 == 0) firstBusy0 = edgeIdx;
    if (a1 != a1Before && firstChange1 == 0) firstChange1 = edgeIdx;
  endtask

  task automatic holdLevel(input logic v, input int n);
    for (int i = 0; i < n; i++) applyStimulus(v);
  endtask

  task automatic doReset(input logic v);
    raw_in = v;
    reset_n = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_a", a0, 0);
    checkOutput("rst_rise", rise0, 0);
    checkOutput("rst_fall", fall0, 0);
    checkOutput("rst_busy", busy0, 0);
    reset_n = 1'b1;
  endtask

  initial begin
    int riseCount;
    int len;
    logic lvl;
    modelReset();
    markEdges();

    // Reset with raw_in high: no strobe on release, rise 7 edges later.
    doReset(1'b1);
    markEdges();
    holdLevel(1'b1, 10);
    checkOutput("t1_rise_edge", firstRise0, 7);

    // Clean 0->1 step: busy from edge 3, rise at edge 7; D=1 follows at edge 4.
    doReset(1'b0);
    holdLevel(1'b0, 4);
    markEdges();
    holdLevel(1'b1, 10);
    checkOutput("t2_busy_edge", firstBusy0, 3);
    checkOutput("t2_rise_edge", firstRise0, 7);
    checkOutput("t6_d1_rise_edge", firstChange1, 4);

    // Bounce 0,1 then hold 0: fall 7 edges after the final 0.
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    markEdges();
    holdLevel(1'b0, 10);
    checkOutput("t4_fall_edge", firstFall0, 7);
    checkOutput("t6_d1_fall_edge", firstChange1, 4);

    // Short glitches every third cycle never reach the D=4 output.
    riseCount = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus((i % 3) == 0);
      if (rise0) riseCount++;
    end
    checkOutput("t3_glitch_rise", riseCount, 0);
    checkOutput("t3_glitch_a", a0, 0);

    // Asynchronous reset in the middle of a count clears outputs without an edge.
    doReset(1'b1);
    holdLevel(1'b1, 5);
    checkOutput("t5_busy_before", busy0, 1);
    #2;
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("t5_async_a", a0, 0);
    checkOutput("t5_async_busy", busy0, 0);
    checkOutput("t5_async_a1", a1, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    markEdges();
    holdLevel(1'b0, 12);
    checkOutput("t5_no_rise", firstRise0, 0);

    // Randomised level runs of varying length against the model.
    for (int seg = 0; seg < 80; seg++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      holdLevel(lvl, len);
    end
    holdLevel(1'b0, 10);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Absolute time limit so the bench always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
